// File: rtl/ppm_tx_pkg.sv
// Shared types and helpers for the PPM frame transmitter.
package ppm_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_CRC,
    ST_GAP
  } ppm_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Advance a CRC-8 over the low m bits of 'bits', MSB-first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [31:0] bits,
                                           input int unsigned m);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(m)) begin
        fb = c[7] ^ bits[i];
        c  = {c[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ppm_tx_fifo.sv
// Single-clock show-ahead FIFO holding words for the PPM transmitter.
module ppm_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (level_q == (AW + 1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem[rd_ptr_q];

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      level_q <= level_q + 1'b1;
      else if (!do_wr && do_rd) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/ppm_frame_tx.sv
// PPM frame transmitter: FIFO-fed framer emitting preamble, L-ary PPM data and
// an optional trailing CRC-8. Define PPM_TX_CRC_EN to enable the CRC symbols.
module ppm_frame_tx
  import ppm_tx_pkg::*;
#(
  parameter int unsigned SLOT_DIV      = 500,
  parameter int unsigned BITS_PER_SYM  = 2,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned FRAME_WORDS   = 8,
  parameter int unsigned PREAMBLE_SYMS = 4,
  parameter int unsigned GUARD_SLOTS   = 0,
  parameter int unsigned GAP_SLOTS     = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          tx_enable,
  input  logic [31:0]                   data_buffer,
  input  logic                          data_buffer_valid,
  output logic                          data_buffer_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ppm_out,
  output logic                          frame_active,
  output logic                          frame_done
);

  localparam int unsigned L         = 1 << BITS_PER_SYM;
  localparam int unsigned SYM_SLOTS = L + GUARD_SLOTS;
  localparam int unsigned PRE_SLOTS = PREAMBLE_SYMS * L;
  localparam int unsigned WORD_SYMS = 32 / BITS_PER_SYM;
  localparam int unsigned CNT_MAX0  = (PRE_SLOTS > SYM_SLOTS) ? PRE_SLOTS : SYM_SLOTS;
  localparam int unsigned CNT_MAX   = (CNT_MAX0 > GAP_SLOTS) ? CNT_MAX0 : GAP_SLOTS;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned SYM_W     = $clog2(WORD_SYMS + 1);
  localparam int unsigned WORD_W    = $clog2(FRAME_WORDS + 1);
  localparam int unsigned DIV_W     = $clog2(SLOT_DIV);
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SLOT_DIV - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST   = CNT_W'(PRE_SLOTS - 1);
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SYM_SLOTS - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_SLOTS - 1);
  localparam logic [SYM_W-1:0]  WSYM_LAST  = SYM_W'(WORD_SYMS - 1);
  localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(FRAME_WORDS - 1);
  localparam logic [LVL_W-1:0]  LVL_FRAME  = LVL_W'(FRAME_WORDS);
`ifdef PPM_TX_CRC_EN
  localparam logic [SYM_W-1:0]  CSYM_LAST  = SYM_W'(8 / BITS_PER_SYM - 1);
`endif

  ppm_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q;
  logic              tick;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              pop, start;
  logic              ppm_d, active_d, done_d;
  logic              ppm_q, active_q, done_q, ready_en_q;
  logic [31:0]       fifo_data;
  logic              fifo_full, fifo_empty;

  ppm_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .wr_en   (data_buffer_valid && data_buffer_ready),
    .wr_data (data_buffer),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign data_buffer_ready = ready_en_q && !fifo_full;
  assign tick              = (div_q == DIV_LAST);
  assign start             = tx_enable && (fifo_level >= LVL_FRAME);
  assign ppm_out           = ppm_q;
  assign frame_active      = active_q;
  assign frame_done        = done_q;

  // Free-running slot divider; ready stays low until the first edge after reset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      ready_en_q <= 1'b1;
    end
  end

`ifdef PPM_TX_CRC_EN
  logic [7:0] crc_q;

  // CRC clears on frame start and absorbs each word as it is popped.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0;
    end else if (tick && state_q == ST_IDLE && start) begin
      crc_q <= '0;
    end else if (pop) begin
      crc_q <= crc8_step(crc_q, fifo_data, 32);
    end
  end
`endif

  // FSM state and slot/symbol/word position registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      word_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      word_q  <= word_d;
      shreg_q <= shreg_d;
    end
  end

  // Next-state: all movement happens on slot ticks; cnt_q is the slot within the section.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    word_d  = word_q;
    shreg_d = shreg_q;
    pop     = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_PREAMBLE;
            cnt_d   = '0;
          end
        end
        ST_PREAMBLE: begin
          if (cnt_q == PRE_LAST) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            sym_d   = '0;
            word_d  = '0;
            pop     = 1'b1;
            shreg_d = fifo_data;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == SLOT_LAST) begin
            cnt_d = '0;
            if (sym_q == WSYM_LAST) begin
              sym_d = '0;
              if (word_q == WORD_LAST) begin
`ifdef PPM_TX_CRC_EN
                state_d = ST_CRC;
                shreg_d = {crc_q, 24'h0};
`else
                state_d = ST_GAP;
`endif
              end else begin
                word_d  = word_q + 1'b1;
                pop     = 1'b1;
                shreg_d = fifo_data;
              end
            end else begin
              sym_d   = sym_q + 1'b1;
              shreg_d = shreg_q << BITS_PER_SYM;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_CRC: begin
`ifdef PPM_TX_CRC_EN
          if (cnt_q == SLOT_LAST) begin
            cnt_d = '0;
            if (sym_q == CSYM_LAST) begin
              sym_d   = '0;
              state_d = ST_GAP;
            end else begin
              sym_d   = sym_q + 1'b1;
              shreg_d = shreg_q << BITS_PER_SYM;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          state_d = ST_IDLE;
`endif
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) state_d = ST_IDLE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode for the slot being entered; guard slots never match a symbol value.
  always_comb begin
    ppm_d = 1'b0;
    unique case (state_d)
      ST_PREAMBLE:     ppm_d = 1'b1;
      ST_DATA, ST_CRC: ppm_d = (cnt_d == CNT_W'(shreg_d[31 -: BITS_PER_SYM]));
      default:         ppm_d = 1'b0;
    endcase
    active_d = (state_d != ST_IDLE);
    done_d   = tick && (state_q == ST_GAP) && (cnt_q == GAP_LAST);
  end

  // Registered line outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ppm_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ppm_q    <= ppm_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_ppm_frame_tx.sv
// Self-checking bench for ppm_frame_tx (small slot timing, one word per frame).
module tb_ppm_frame_tx;

  localparam int unsigned SLOT_DIV = 4;
  localparam int unsigned L        = 4;
  localparam int unsigned PRE      = 2;
  localparam int unsigned GAP      = 4;
`ifdef PPM_TX_CRC_EN
  localparam int unsigned NSYM = 20;
`else
  localparam int unsigned NSYM = 16;
`endif
  localparam int unsigned PRE_CYC   = PRE * L * SLOT_DIV;
  localparam int unsigned SYM_CYC   = L * SLOT_DIV;
  localparam int unsigned FRAME_CYC = PRE_CYC + NSYM * SYM_CYC + GAP * SLOT_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_enable = 1'b0;
  logic [31:0] data_buffer = '0;
  logic        data_buffer_valid = 1'b0;
  logic        data_buffer_ready;
  logic [4:0]  fifo_level;
  logic        ppm_out, frame_active, frame_done;

  ppm_frame_tx #(
    .SLOT_DIV      (SLOT_DIV),
    .BITS_PER_SYM  (2),
    .FIFO_DEPTH    (16),
    .FRAME_WORDS   (1),
    .PREAMBLE_SYMS (PRE),
    .GUARD_SLOTS   (0),
    .GAP_SLOTS     (GAP)
  ) dut (
    .CLOCK_50          (clk),
    .reset_n           (reset_n),
    .tx_enable         (tx_enable),
    .data_buffer       (data_buffer),
    .data_buffer_valid (data_buffer_valid),
    .data_buffer_ready (data_buffer_ready),
    .fifo_level        (fifo_level),
    .ppm_out           (ppm_out),
    .frame_active      (frame_active),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  s0, s1, s2, s3, slast;
  } vec_t;

  vec_t        vecs [5];
  logic [2:0]  sb_q [$];   // {ppm_out, frame_active, frame_done} per cycle
  int          checks = 0;
  int          errors = 0;
  int          sym_meas [NSYM];
  int          done_cnt;
  logic [31:0] fill_words [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_crc(input logic [31:0] w);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ w[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'h07;
    end
    return c;
  endfunction

  // Expected waveform from the first active cycle through the following idle slot.
  task automatic push_frame(input logic [31:0] w);
    logic [39:0] bits;
    logic [1:0]  v;
    logic        p;
    bits = {w, model_crc(w)};
    repeat (PRE_CYC) sb_q.push_back(3'b110);
    for (int s = 0; s < int'(NSYM); s++) begin
      v = bits[39 - 2 * s -: 2];
      for (int slot = 0; slot < int'(L); slot++) begin
        p = (slot == int'(v));
        repeat (SLOT_DIV) sb_q.push_back({p, 1'b1, 1'b0});
      end
    end
    repeat (GAP * SLOT_DIV) sb_q.push_back(3'b010);
    sb_q.push_back(3'b001);
    repeat (SLOT_DIV - 1) sb_q.push_back(3'b000);
  endtask

  task automatic write_word(input logic [31:0] w);
    data_buffer       = w;
    data_buffer_valid = 1'b1;
    step();
    data_buffer_valid = 1'b0;
  endtask

  // Wait for a frame to begin, then compare every cycle against the scoreboard.
  task automatic check_stream(input int drop_at);
    int         n;
    int         waited;
    int         d;
    logic [2:0] e;
    logic [2:0] act;
    n        = 0;
    waited   = 0;
    done_cnt = 0;
    for (int i = 0; i < int'(NSYM); i++) sym_meas[i] = -1;
    while (!frame_active && waited < 40) begin
      step();
      waited++;
    end
    check("frame_start", frame_active, 1);
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {ppm_out, frame_active, frame_done};
      if (n == drop_at) tx_enable = 1'b0;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL stream[%0d]: got ppm/active/done=%b expected %b", n, act, e);
      end
      if (frame_done) done_cnt++;
      if (ppm_out && n >= int'(PRE_CYC) && n < int'(PRE_CYC + NSYM * SYM_CYC)) begin
        d = n - int'(PRE_CYC);
        sym_meas[d / int'(SYM_CYC)] = (d % int'(SYM_CYC)) / int'(SLOT_DIV);
      end
      n++;
      step();
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{32'h1B000000, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    vecs[1] = '{32'h00000001, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    vecs[2] = '{32'hFFFFFFFF, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    vecs[3] = '{32'hA5A5A5A5, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    vecs[4] = '{32'hE4000003, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

    // Reset state
    step();
    step();
    check("rst_ppm", ppm_out, 0);
    check("rst_active", frame_active, 0);
    check("rst_done", frame_done, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", data_buffer_ready, 0);
    reset_n = 1'b1;
    step();
    step();
    check("ready_after_rst", data_buffer_ready, 1);

    // Table-driven single frames
    tx_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_frame(vecs[i].data);
      write_word(vecs[i].data);
      check("level_after_write", fifo_level, 1);
      check_stream(-1);
      check("sym0", sym_meas[0], vecs[i].s0);
      check("sym1", sym_meas[1], vecs[i].s1);
      check("sym2", sym_meas[2], vecs[i].s2);
      check("sym3", sym_meas[3], vecs[i].s3);
      check("sym_last", sym_meas[15], vecs[i].slast);
      check("frame_done_count", done_cnt, 1);
      check("level_after_frame", fifo_level, 0);
    end

    // Fill to full with valid held high; the 17th write must be dropped
    tx_enable         = 1'b0;
    data_buffer_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      fill_words[i] = 32'h5A000000 | (32'(i) * 32'h00111111);
      data_buffer   = fill_words[i];
      step();
      if (i == 15) begin
        check("ready_full", data_buffer_ready, 0);
        check("level_full", fifo_level, 16);
      end
    end
    data_buffer_valid = 1'b0;
    check("level_after_drop", fifo_level, 16);
    check("ready_still_low", data_buffer_ready, 0);

    // Back-to-back frames, tx_enable dropped mid-DATA of the third
    push_frame(fill_words[0]);
    push_frame(fill_words[1]);
    push_frame(fill_words[2]);
    tx_enable = 1'b1;
    check_stream(2 * int'(FRAME_CYC + SLOT_DIV) + int'(PRE_CYC) + 40);
    check("b2b_done_count", done_cnt, 3);
    cnt = 0;
    repeat (40) begin
      if (frame_active) cnt++;
      step();
    end
    check("no_start_when_disabled", cnt, 0);
    check("level_after_b2b", fifo_level, 13);
    check("ready_after_pops", data_buffer_ready, 1);

    // Reset asserted mid-preamble
    tx_enable = 1'b1;
    cnt = 0;
    while (!frame_active && cnt < 40) begin
      step();
      cnt++;
    end
    check("pre_start", frame_active, 1);
    repeat (10) step();
    check("mid_preamble_ppm", ppm_out, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_ppm", ppm_out, 0);
    check("async_rst_active", frame_active, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_ready", data_buffer_ready, 0);
    step();
    step();
    reset_n = 1'b1;
    cnt = 0;
    repeat (40) begin
      if (ppm_out || frame_active || frame_done) cnt++;
      step();
    end
    check("no_residual_after_rst", cnt, 0);

`ifdef PPM_TX_CRC_EN
    // CRC of 0x00000001 is 0x07 -> trailing symbols 0,0,1,3
    push_frame(32'h00000001);
    write_word(32'h00000001);
    check_stream(-1);
    check("crc_sym0", sym_meas[16], 0);
    check("crc_sym1", sym_meas[17], 0);
    check("crc_sym2", sym_meas[18], 1);
    check("crc_sym3", sym_meas[19], 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
